// File: rtl/axis_img_border_filter.sv
// AXI-Stream pixel filter: keeps or drops pixels by border-flag bits, optionally strips the
// flag, and regenerates tlast every LINE_WIDTH kept pixels with line-length error tracking.
module axis_img_border_filter #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] FLAG_MASK    = DATA_WIDTH'(16'h8000),
    parameter bit                    KEEP_FLAGGED = 1'b1,
    parameter bit                    STRIP_FLAG   = 1'b1,
    parameter int                    LINE_WIDTH   = 640
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  line_err,
    output logic [15:0]           err_count
);

    localparam logic [15:0] LW = 16'(LINE_WIDTH);

    logic                  r_rst_d;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_m_user;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [15:0]           r_col;
    logic                  r_sof_pend;
    logic                  r_line_err;
    logic [15:0]           r_err_count;

    logic                  w_accept;
    logic                  w_flag;
    logic                  w_keep;
    logic                  w_kept;
    logic                  w_sof;
    logic                  w_eol;
    logic                  w_short;
    logic [15:0]           w_col_base;
    logic [15:0]           w_col_cnt;
    logic [DATA_WIDTH-1:0] w_out_data;

    assign s_axis_tready = (~r_m_valid | m_axis_tready) & ~axis_areset & ~r_rst_d;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_flag        = |(s_axis_tdata & FLAG_MASK);
    assign w_keep        = KEEP_FLAGGED ? w_flag : ~w_flag;
    assign w_kept        = w_accept & w_keep;
    // A tuser beat opens a new frame before it is itself counted or tagged.
    assign w_sof         = r_sof_pend | (w_accept & s_axis_tuser);
    assign w_out_data    = STRIP_FLAG ? (s_axis_tdata & ~FLAG_MASK) : s_axis_tdata;

    always_comb begin
        w_col_base = (w_accept & s_axis_tuser) ? 16'd0 : r_col;
        w_col_cnt  = w_col_base;
        w_eol      = 1'b0;
        if (w_kept) begin
            if (w_col_base + 16'd1 == LW) begin
                w_eol     = 1'b1;
                w_col_cnt = 16'd0;
            end else begin
                w_col_cnt = w_col_base + 16'd1;
            end
        end
    end

    assign w_short = w_accept & s_axis_tlast & (w_col_cnt != 16'd0);

    always_ff @(posedge axis_aclk) begin
        r_rst_d <= axis_areset;
        if (axis_areset) begin
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_user    <= 1'b0;
            r_m_data    <= '0;
            r_col       <= 16'd0;
            r_sof_pend  <= 1'b0;
            r_line_err  <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            if (w_kept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_out_data;
                r_m_last  <= w_eol;
                r_m_user  <= w_sof;
            end else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                // Input tlast always closes the line; a short line is flagged, not patched.
                r_col      <= s_axis_tlast ? 16'd0 : w_col_cnt;
                r_sof_pend <= w_sof & ~w_kept;
            end
            r_line_err <= w_short;
            if (r_line_err && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;
    assign line_err      = r_line_err;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_axis_img_border_filter.sv
// Bench for axis_img_border_filter: directed and random streams checked against a
// frame/line reference model; a second instance covers the inverted-keep, no-strip mode.
module tb_axis_img_border_filter;

    localparam logic [15:0] MASK = 16'h8000;
    localparam int          LW   = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_user = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        m_user;
    logic        line_err;
    logic [15:0] err_count;

    logic [15:0] b_s_data = '0;
    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [15:0] b_m_data;
    logic        b_m_valid;
    logic        b_m_last;
    logic        b_m_user;
    logic        b_line_err;
    logic [15:0] b_err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_img_border_filter #(.DATA_WIDTH(16), .LINE_WIDTH(LW)) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user),
        .line_err(line_err), .err_count(err_count)
    );

    axis_img_border_filter #(
        .DATA_WIDTH(16), .KEEP_FLAGGED(1'b0), .STRIP_FLAG(1'b0), .LINE_WIDTH(LW)
    ) dut_b (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(b_s_data), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
        .s_axis_tlast(1'b0), .s_axis_tuser(1'b0),
        .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(1'b1),
        .m_axis_tlast(b_m_last), .m_axis_tuser(b_m_user),
        .line_err(b_line_err), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model state: expected output beats in flight, line/frame position, errors.
    beat_t       q[$];
    int          m_col = 0;
    bit          m_sof = 1'b0;
    bit          pend_err = 1'b0;
    logic [15:0] m_errcnt = '0;
    bit          prev_rst = 1'b1;
    bit          mon_en = 1'b0;
    bit          acc_flag = 1'b0;
    bit          exp_mv;
    bit          exp_sr;
    beat_t       nb;

    task automatic model_accept(input logic [15:0] d, input bit last, input bit user);
        beat_t e;
        if (user) begin
            m_sof = 1'b1;
            m_col = 0;
        end
        if ((d & MASK) != 16'd0) begin
            m_col++;
            e.d    = d & ~MASK;
            e.last = (m_col == LW);
            e.user = m_sof;
            if (e.last) m_col = 0;
            m_sof = 1'b0;
            q.push_back(e);
        end
        if (last && m_col != 0) begin
            pend_err = 1'b1;
            m_col    = 0;
        end
    endtask

    // Inputs change #1 after posedge; everything is sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_mv = (q.size() != 0);
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
            if (exp_mv) begin
                nb = q[0];
                chk("m_data", {16'd0, m_data}, {16'd0, nb.d});
                chk("m_last", {31'd0, m_last}, {31'd0, nb.last});
                chk("m_user", {31'd0, m_user}, {31'd0, nb.user});
            end
            exp_sr = (!exp_mv || m_ready) && !rst && !prev_rst;
            chk("s_ready", {31'd0, s_ready}, {31'd0, exp_sr});
            chk("line_err", {31'd0, line_err}, {31'd0, pend_err});
            chk("err_count", {16'd0, err_count}, {16'd0, m_errcnt});
            if (pend_err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
            pend_err = 1'b0;
            acc_flag = 1'b0;
            if (rst) begin
                q.delete();
                m_col    = 0;
                m_sof    = 1'b0;
                m_errcnt = '0;
            end else begin
                if (exp_mv && m_ready) void'(q.pop_front());
                if (s_valid && exp_sr) begin
                    acc_flag = 1'b1;
                    model_accept(s_data, s_last, s_user);
                end
            end
        end
        prev_rst = rst;
    end

    // m_ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random, 3 held low.
    int rmode = 0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: begin
                m_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end
            2: m_ready = 1'($urandom_range(0, 1));
            3: m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit last, input bit user);
        int n = 0;
        s_data  = d;
        s_last  = last;
        s_user  = user;
        s_valid = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 64);
        if (!acc_flag) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=%0d cycles expected=accept", n);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
    endtask

    task automatic pass_line(input bit sof);
        send(16'h0001, 1'b0, sof);
        send(16'h8010, 1'b0, 1'b0);
        send(16'h8011, 1'b0, 1'b0);
        send(16'h8012, 1'b0, 1'b0);
        send(16'h8013, 1'b0, 1'b0);
        send(16'h0002, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle(3);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {16'd0, m_data}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_user", {31'd0, m_user}, 32'd0);
        chk("rst_line_err", {31'd0, line_err}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;
        idle(2);

        // Inverted keep, no strip: 0x8001 dropped, others unmodified
        b_s_valid = 1'b1;
        b_s_data  = 16'h8001;
        idle(1);
        b_s_data  = 16'h0005;
        idle(1);
        b_s_data  = 16'h0006;
        @(negedge clk);
        chk("b_valid0", {31'd0, b_m_valid}, 32'd1);
        chk("b_data0", {16'd0, b_m_data}, 32'h0005);
        @(posedge clk);
        #1;
        b_s_valid = 1'b0;
        @(negedge clk);
        chk("b_valid1", {31'd0, b_m_valid}, 32'd1);
        chk("b_data1", {16'd0, b_m_data}, 32'h0006);
        @(negedge clk);
        chk("b_valid2", {31'd0, b_m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Passthrough, tuser on a dropped first pixel
        pass_line(1'b1);
        pass_line(1'b0);
        idle(2);

        // Backpressure 1,0,0,1
        rmode = 1;
        pass_line(1'b1);
        pass_line(1'b0);
        rmode = 0;
        idle(3);

        // Short line ending on a dropped pixel, then a good line
        send(16'h8020, 1'b0, 1'b0);
        send(16'h8021, 1'b0, 1'b0);
        send(16'h8022, 1'b0, 1'b0);
        send(16'h0003, 1'b1, 1'b0);
        pass_line(1'b0);
        idle(2);

        // tuser on a kept pixel; tuser+tlast on one kept beat
        send(16'h8030, 1'b0, 1'b1);
        send(16'h8031, 1'b0, 1'b0);
        send(16'h8032, 1'b0, 1'b0);
        send(16'h8033, 1'b1, 1'b0);
        send(16'h8040, 1'b0, 1'b0);
        send(16'h8042, 1'b1, 1'b1);
        idle(2);

        // Frame of dropped beats only keeps SOF pending for the next kept pixel
        send(16'h0001, 1'b0, 1'b1);
        send(16'h0002, 1'b1, 1'b0);
        pass_line(1'b0);
        idle(2);

        // Random traffic
        rmode = 2;
        for (int i = 0; i < 300; i++) begin
            send(16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rmode = 0;
        idle(4);

        // Make sure err_count is non-zero before the mid-line reset
        send(16'h8060, 1'b1, 1'b0);
        idle(3);

        // Reset while a beat is held under backpressure
        rmode = 3;
        send(16'h8050, 1'b0, 1'b1);
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_err_count", {16'd0, err_count}, 32'd0);
        rst = 1'b0;
        rmode = 0;
        @(negedge clk);
        chk("post_rst_s_ready0", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("post_rst_s_ready1", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(16'h8070, 1'b0, 1'b0);
        send(16'h8071, 1'b0, 1'b0);
        send(16'h8072, 1'b0, 1'b0);
        send(16'h8073, 1'b1, 1'b0);
        idle(4);
        chk("drain", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_img_border_filter.md
AXIS_IMG_BORDER_FILTER -- requirements
Module: axis_img_border_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width in bits (range 8..32).
REQ-002 SHALL have parameter FLAG_MASK, default 16'h8000 (DATA_WIDTH bits), marking the border-flag bit(s) set by the border generator.
REQ-003 SHALL have parameter KEEP_FLAGGED, default 1:
- 1 = pass pixels with any FLAG_MASK bit set.
- 0 = pass pixels with no FLAG_MASK bit set.
REQ-004 SHALL have parameter STRIP_FLAG, default 1:
- 1 = clear FLAG_MASK bits in output data.
- 0 = pass data unmodified.
REQ-005 SHALL have parameter LINE_WIDTH, default 640, the number of kept pixels per output line (1..65535).
REQ-006 SHALL have port axis_aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port axis_areset, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port s_axis_tdata, input, DATA_WIDTH, input pixel.
REQ-009 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tlast (input, 1, end of input line) and s_axis_tuser (input, 1, start of frame).
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH, kept pixel.
REQ-011 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1, regenerated end of line) and m_axis_tuser (output, 1, start of frame).
REQ-012 SHALL have port line_err, output, 1, one-cycle pulse on an input line-length mismatch.
REQ-013 SHALL have port err_count, output, 16, saturating count of line_err pulses.

Function
REQ-014 An input beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high.
REQ-015 s_axis_tready SHALL equal (~m_axis_tvalid | m_axis_tready) & ~axis_areset & ~rst_d, where rst_d is axis_areset delayed by one cycle.
REQ-016 A beat SHALL be kept when its flag match per KEEP_FLAGGED is true; otherwise it is dropped.
REQ-017 A dropped beat SHALL be consumed without changing any m_axis output.
REQ-018 A kept beat SHALL be loaded into the output register on the next edge, so latency is 1 cycle and throughput is 1 beat/cycle with no bubbles.
REQ-019 The output register SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 m_axis_tvalid SHALL clear after an output handshake when no kept beat is accepted in the same cycle; when one is, it stays high with the new data.
REQ-021 Output data SHALL be s_axis_tdata & ~FLAG_MASK when STRIP_FLAG=1, and s_axis_tdata otherwise.
REQ-022 A 16-bit column counter col SHALL count kept accepted beats; the beat that makes col reach LINE_WIDTH SHALL be output with m_axis_tlast=1, and col SHALL return to 0.
REQ-023 An accepted beat with s_axis_tuser=1 SHALL set sof_pend and force col to 0 before that beat is counted.
REQ-024 The first kept beat accepted while sof_pend=1 (including the same tuser beat) SHALL be output with m_axis_tuser=1 and SHALL clear sof_pend.
REQ-025 On an accepted beat with s_axis_tlast=1, the block SHALL check col after that beat is counted:
- col=0 (line complete): no error.
- col!=0: line_err pulses high on the next cycle and col clears to 0; no m_axis_tlast is inserted for the short line.
REQ-026 err_count SHALL increment on each line_err pulse and saturate at 16'hFFFF.
REQ-027 A frame containing only dropped beats SHALL produce no output and SHALL leave sof_pend set.
REQ-028 When tuser and tlast occur on the same beat, REQ-023 SHALL apply first, then REQ-025.

Reset
REQ-029 While axis_areset=1 at a clock edge, the block SHALL set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, col=0, sof_pend=0, line_err=0 and err_count=0.
REQ-030 The same values SHALL also be the power-up initial values.
REQ-031 s_axis_tready SHALL be 0 during reset and for 1 cycle after reset deasserts.
REQ-032 Reset asserted mid-line SHALL discard the held output beat and any partial-line state, with no pending tlast or tuser carried over.

Verification
REQ-033 Passthrough: LINE_WIDTH=4; input per line is [0x0001, 0x8010, 0x8011, 0x8012, 0x8013, 0x0002] with tlast on the last beat; m_ready=1 -> output 0x0010..0x0013, tlast on 0x0013, line_err=0, no idle cycles between kept beats.
REQ-034 Backpressure: same stream with m_axis_tready toggling 1,0,0,1 -> no beat lost or duplicated, data stable while stalled, s_axis_tready low exactly when m_valid=1 and m_ready=0.
REQ-035 Short line: LINE_WIDTH=4, line with 3 flagged pixels, tlast on a dropped pixel -> no m_tlast, line_err pulse 1 cycle after the tlast beat, err_count=1, the next line is output correctly.
REQ-036 SOF: tuser on a dropped first pixel -> the next kept pixel has m_tuser=1, later pixels have m_tuser=0; tuser on a kept pixel -> that pixel has m_tuser=1.
REQ-037 KEEP_FLAGGED=0, STRIP_FLAG=0: input [0x8001, 0x0005, 0x0006] -> output [0x0005, 0x0006] unmodified.
REQ-038 Reset while m_valid=1 and m_ready=0 -> m_valid=0 the next cycle, s_ready=0 for 1 cycle after release, err_count=0.
